sprite_actor_engine: RTL

//  Parametrised successor to the fixed-size fighter sprite blocks. Owns one on-screen actor:
//  - tick-paced movement/knockback FSM with clamp and opponent collision
//  - per-animation frame sequencing (looping and one-shot)
//  - 2-stage pixel pipeline driving an external sprite ROM, with aligned palette/hit outputs

---
 rtl/sprite_actor_engine.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_actor_engine.sv
// Sprite actor engine: one on-screen actor.
// - Movement, knockback, attack and hurt states, stepped once per frame tick.
// - Animation frame sequencing.
// - Pixel pipeline that addresses an external sprite ROM.
module sprite_actor_engine #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned NUM_ANIM    = 5,
    parameter logic [NUM_ANIM*8-1:0]      ANIM_FW   = {8'd16, 8'd16, 8'd16, 8'd16, 8'd16},
    parameter logic [NUM_ANIM*8-1:0]      ANIM_FH   = {8'd24, 8'd24, 8'd24, 8'd24, 8'd24},
    parameter logic [NUM_ANIM*4-1:0]      ANIM_NF   = {4'd2, 4'd4, 4'd4, 4'd3, 4'd4},
    parameter logic [NUM_ANIM*ADDR_W-1:0] ANIM_BASE = {ADDR_W'(5760), ADDR_W'(4224),
                                                       ADDR_W'(2688), ADDR_W'(1536), ADDR_W'(0)},
    parameter int unsigned FRAME_DIV   = 6,
    parameter int unsigned START_X     = 10,
    parameter int unsigned START_Y     = 200,
    parameter int unsigned X_MIN       = 10,
    parameter int unsigned X_MAX       = 630,
    parameter int unsigned MOVE_STEP   = 2,
    parameter int unsigned KNOCK_STEP  = 8,
    parameter int unsigned KNOCK_TICKS = 5,
    parameter int unsigned COLLIDE_W   = 50,
    parameter logic [7:0]  TRANSP_IDX  = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              move_l,
    input  logic              move_r,
    input  logic              attack_req,
    input  logic              hurt_pulse,
    input  logic [ADDR_W-1:0] opp_x,
    input  logic              opp_solid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] actor_x,
    output logic [2:0]        anim_id,
    output logic              anim_done,
    output logic              is_character,
    output logic [7:0]        data_Out
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned KC_W  = $clog2(KNOCK_TICKS + 1);

    localparam logic [2:0] ANIM_STAND  = 3'd0;
    localparam logic [2:0] ANIM_ATTACK = 3'd1;
    localparam logic [2:0] ANIM_MOVE_L = 3'd2;
    localparam logic [2:0] ANIM_MOVE_R = 3'd3;
    localparam logic [2:0] ANIM_HURT   = 3'd4;

    typedef logic signed [ADDR_W:0] spos_t;

    localparam spos_t X_MIN_S     = spos_t'(X_MIN);
    localparam spos_t X_MAX_S     = spos_t'(X_MAX);
    localparam spos_t COLLIDE_W_S = spos_t'(COLLIDE_W);
    localparam spos_t ACTOR_Y     = spos_t'(START_Y);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_ATTACK,
        ST_KNOCK
    } state_t;

    state_t            state;
    logic [2:0]        fsync;
    logic              tick;
    logic [3:0]        frame;
    logic [DIV_W-1:0]  div;
    logic [KC_W-1:0]   knock_cnt;

    // Geometry of the active animation
    logic [7:0]        fw_cur;
    logic [7:0]        fh_cur;
    logic [3:0]        nf_cur;
    logic [ADDR_W-1:0] base_cur;

    always_comb begin
        fw_cur   = ANIM_FW[anim_id*8 +: 8];
        fh_cur   = ANIM_FH[anim_id*8 +: 8];
        nf_cur   = ANIM_NF[anim_id*4 +: 4];
        base_cur = ANIM_BASE[anim_id*ADDR_W +: ADDR_W];
    end

    // frame_clk synchroniser; tick is a registered one-cycle rising-edge pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync <= '0;
            tick  <= 1'b0;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
            tick  <= fsync[1] & ~fsync[2];
        end
    end

    // Looping frame step for the current animation
    logic             div_wrap;
    logic             frame_last;
    logic [3:0]       step_frame;
    logic [DIV_W-1:0] step_div;

    always_comb begin
        div_wrap   = (div == DIV_W'(FRAME_DIV - 1));
        frame_last = (frame == nf_cur - 4'd1);
        step_div   = div_wrap ? '0 : div + 1'b1;
        step_frame = frame;
        if (div_wrap) begin
            step_frame = frame_last ? '0 : frame + 4'd1;
        end
    end

    // Next x: signed step, then opponent collision, then screen clamp (clamp wins)
    spos_t             nx;
    spos_t             span_hi;
    spos_t             delta;
    logic [ADDR_W-1:0] nx_u;
    logic [2:0]        walk_anim;

    always_comb begin
        span_hi = X_MAX_S - (spos_t'(fw_cur) <<< SCALE_SHIFT);
        if (state == ST_KNOCK) begin
            delta = -spos_t'(KNOCK_STEP);
        end else if (move_r) begin
            delta = spos_t'(MOVE_STEP);
        end else begin
            delta = -spos_t'(MOVE_STEP);
        end
        nx = spos_t'(actor_x) + delta;
        if (opp_solid && ((nx + COLLIDE_W_S) > spos_t'(opp_x))) begin
            nx = spos_t'(opp_x) - COLLIDE_W_S;
        end
        if (nx < X_MIN_S) begin
            nx = X_MIN_S;
        end else if (nx > span_hi) begin
            nx = span_hi;
        end
        nx_u      = nx[ADDR_W-1:0];
        walk_anim = move_r ? ANIM_MOVE_R : ANIM_MOVE_L;
    end

    // Actor FSM: hurt pre-empts on any cycle, everything else advances on tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            actor_x   <= ADDR_W'(START_X);
            anim_id   <= ANIM_STAND;
            anim_done <= 1'b0;
            frame     <= '0;
            div       <= '0;
            knock_cnt <= '0;
        end else begin
            anim_done <= 1'b0;
            if (hurt_pulse) begin
                state     <= ST_KNOCK;
                knock_cnt <= '0;
                anim_id   <= ANIM_HURT;
                if (anim_id != ANIM_HURT) begin
                    frame <= '0;
                    div   <= '0;
                end
            end else if (tick) begin
                case (state)
                    ST_IDLE, ST_WALK: begin
                        if (attack_req) begin
                            state   <= ST_ATTACK;
                            anim_id <= ANIM_ATTACK;
                            frame   <= '0;
                            div     <= '0;
                        end else if (move_l ^ move_r) begin
                            state   <= ST_WALK;
                            actor_x <= nx_u;
                            anim_id <= walk_anim;
                            if (anim_id != walk_anim) begin
                                frame <= '0;
                                div   <= '0;
                            end else begin
                                frame <= step_frame;
                                div   <= step_div;
                            end
                        end else begin
                            state   <= ST_IDLE;
                            anim_id <= ANIM_STAND;
                            if (anim_id != ANIM_STAND) begin
                                frame <= '0;
                                div   <= '0;
                            end else begin
                                frame <= step_frame;
                                div   <= step_div;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        div <= step_div;
                        if (div_wrap) begin
                            if (frame_last) begin
                                state     <= ST_IDLE;
                                anim_id   <= ANIM_STAND;
                                frame     <= '0;
                                div       <= '0;
                                anim_done <= 1'b1;
                            end else begin
                                frame <= frame + 4'd1;
                            end
                        end
                    end
                    ST_KNOCK: begin
                        actor_x <= nx_u;
                        if (knock_cnt == KC_W'(KNOCK_TICKS - 1)) begin
                            state   <= ST_IDLE;
                            anim_id <= ANIM_STAND;
                            frame   <= '0;
                            div     <= '0;
                        end else begin
                            knock_cnt <= knock_cnt + 1'b1;
                            frame     <= step_frame;
                            div       <= step_div;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Pixel stage 0: hit test and ROM address, all from the same geometry snapshot
    spos_t             dx;
    spos_t             dy;
    logic              hit;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] pix_addr;

    always_comb begin
        dx  = spos_t'(DrawX) - spos_t'(actor_x);
        dy  = spos_t'(DrawY) - ACTOR_Y;
        hit = !dx[ADDR_W] && (dx < (spos_t'(fw_cur) <<< SCALE_SHIFT)) &&
              !dy[ADDR_W] && (dy < (spos_t'(fh_cur) <<< SCALE_SHIFT));
        col = dx[ADDR_W-1:0] >> SCALE_SHIFT;
        row = dy[ADDR_W-1:0] >> SCALE_SHIFT;
        pix_addr = base_cur
                 + ADDR_W'(frame) * ADDR_W'(fw_cur) * ADDR_W'(fh_cur)
                 + row * ADDR_W'(fw_cur)
                 + col;
    end

    logic hit_d;

    // Pixel stages 1-2: register address with hit, then register ROM data with transparency
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr     <= '0;
            hit_d        <= 1'b0;
            data_Out     <= '0;
            is_character <= 1'b0;
        end else begin
            rom_addr     <= hit ? pix_addr : '0;
            hit_d        <= hit;
            data_Out     <= rom_data;
            is_character <= hit_d && (rom_data != TRANSP_IDX);
        end
    end

endmodule
